uart_tx_unit: RTL and testbench
===============================

Name: uart_tx_unit

Overview:
UART transmitter. Serialises one 8-bit byte per frame onto a single line: start bit, 8 data bits LSB first, parity slot, stop bit. Runtime-selectable baud rate (4 rates) and parity mode, derived from the 50 MHz system clock. Sits between a byte producer (send/data_in) and the TX pin; exports busy and done status.

Parameters:
CLK_HZ, 50000000, system clock frequency in Hz.
Bit divisor per rate = round(CLK_HZ / baud). At the default CLK_HZ these are 2400 -> 20833, 4800 -> 10417, 9600 -> 5208, 19200 -> 2604 cycles per bit.

Ports:
clock  in  1  system clock; all logic on the rising edge.
reset  in  1  synchronous, active-high reset.
send  in  1  level request to transmit; sampled only while idle.
data_in  in  8  byte to send; latched at frame start.
parity_type  in  2  parity mode: 00 none, 01 odd, 10 even, 11 none. Latched at frame start.
baud_rate  in  2  rate: 00 2400, 01 4800, 10 9600, 11 19200. Latched at frame start.
data_tx  out  1  serial line; idles high.
active_flag  out  1  high while a frame is on the line.
done_flag  out  1  one-cycle pulse at frame completion.

Behaviour:
- Reset (synchronous, active-high, highest priority, also mid-frame): state IDLE, data_tx=1, active_flag=0, done_flag=0, counters cleared. Any frame in progress is aborted with no done pulse.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: data_tx=1, active_flag=0. On a rising edge with send=1:
  - latch data_in, parity_type and baud_rate;
  - go to START;
  - from the next cycle: data_tx=0, active_flag=1.
- Each bit state holds its data_tx value for exactly DIV cycles, where DIV is the latched rate's divisor. A bit counter, reloaded per bit, counts 0..DIV-1.
- START: data_tx=0 for DIV cycles, then DATA.
- DATA: bits data[0]..data[7], one per DIV cycles, then PARITY.
- PARITY: data_tx = parity bit for DIV cycles, then STOP.
  - Odd mode: bit = ~^data, so the total count of ones is odd.
  - Even mode: bit = ^data.
  - None modes (00 and 11): bit = 1, transmitted as a mark. Frame length is always 11 bits.
- STOP: data_tx=1 for DIV cycles. On the last stop cycle's edge:
  - return to IDLE;
  - done_flag=1 for exactly one cycle;
  - active_flag=0 in that same cycle.
- Total frame time = 11*DIV cycles from the first start-bit cycle to the done pulse.
- Back-to-back frames: if send is high during the done-pulse cycle, the next start bit begins on the following cycle. The minimum inter-frame gap is 1 clock of idle high.
- Changes to data_in, parity_type or baud_rate mid-frame have no effect on the current frame.
- send dropping mid-frame does not abort the frame.
- Outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
Macro UART_TX_TWO_STOP_EN.
- Defined: the STOP state emits two stop bits (2*DIV cycles high). Frame = 12*DIV cycles; the done pulse follows the second stop bit.
- Undefined: one stop bit, 11*DIV-cycle frame as specified above.

Test Plan:
- Reset: hold reset=1 for 5 cycles with send=1 -> data_tx=1, active_flag=0, done_flag=0 throughout.
- 9600 odd parity, data_in=0xAA (baud_rate=10, parity_type=01), send=1:
  - line = 0, then 0,1,0,1,0,1,0,1, parity 1, stop 1; each bit 5208 cycles;
  - active_flag high for 57288 cycles; single done pulse.
- 19200 even parity, data_in=0xAA (baud_rate=11, parity_type=10): parity bit 0, each bit 2604 cycles, frame 28644 cycles, done pulse at end.
- No parity, data_in=0x01 with parity_type=00 and again with 11 -> parity slot = 1 in both cases.
- send held high for 2 frames at 19200 -> second start bit begins exactly 1 cycle after the first done pulse; exactly two done pulses.
- Reset asserted mid-DATA -> next cycle data_tx=1, active_flag=0, no done pulse. After release with send=1, a fresh, correct frame is sent.
- Change data_in and baud_rate mid-frame -> current frame bits and timing unchanged.

Source files
------------

// File: rtl/uart_tx_unit.sv
// UART transmitter: start, 8 data bits LSB first, parity slot, stop; four runtime baud rates.
// Optional macro UART_TX_TWO_STOP_EN: emit two stop bits (12-bit frame) instead of one.
module uart_tx_unit #(
    parameter int CLK_HZ = 50000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       send,
    input  logic [7:0] data_in,
    input  logic [1:0] parity_type,
    input  logic [1:0] baud_rate,
    output logic       data_tx,
    output logic       active_flag,
    output logic       done_flag
);

    localparam int DIV_2400  = (CLK_HZ + 1200) / 2400;
    localparam int DIV_4800  = (CLK_HZ + 2400) / 4800;
    localparam int DIV_9600  = (CLK_HZ + 4800) / 9600;
    localparam int DIV_19200 = (CLK_HZ + 9600) / 19200;
    localparam int CW        = $clog2(DIV_2400 + 1);
    localparam logic [CW-1:0] ONE = 1;

`ifdef UART_TX_TWO_STOP_EN
    localparam logic ONE_STOP = 1'b0;
`else
    localparam logic ONE_STOP = 1'b1;
`endif

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   div_q;
    logic [2:0]      bit_idx;
    logic [7:0]      shreg;
    logic            par_bit;
    logic            stop2;
    logic            bit_end;
    logic            last_stop;

    assign bit_end   = (cnt == div_q - ONE);
    assign last_stop = stop2 | ONE_STOP;

    function automatic logic [CW-1:0] div_sel(input logic [1:0] b);
        case (b)
            2'b00:   return CW'(DIV_2400);
            2'b01:   return CW'(DIV_4800);
            2'b10:   return CW'(DIV_9600);
            default: return CW'(DIV_19200);
        endcase
    endfunction

    // None modes still occupy the slot, sent as a mark so frame length is fixed.
    function automatic logic par_sel(input logic [7:0] d, input logic [1:0] p);
        case (p)
            2'b01:   return ~^d;
            2'b10:   return ^d;
            default: return 1'b1;
        endcase
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            data_tx     <= 1'b1;
            active_flag <= 1'b0;
            done_flag   <= 1'b0;
            cnt         <= '0;
            div_q       <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            par_bit     <= 1'b1;
            stop2       <= 1'b0;
        end else begin
            done_flag <= 1'b0;
            if (state == IDLE) begin
                data_tx     <= 1'b1;
                active_flag <= 1'b0;
                if (send) begin
                    shreg       <= data_in;
                    par_bit     <= par_sel(data_in, parity_type);
                    div_q       <= div_sel(baud_rate);
                    cnt         <= '0;
                    state       <= START;
                    data_tx     <= 1'b0;
                    active_flag <= 1'b1;
                end
            end else if (!bit_end) begin
                cnt <= cnt + ONE;
            end else begin
                cnt <= '0;
                case (state)
                    START: begin
                        state   <= DATA;
                        bit_idx <= '0;
                        data_tx <= shreg[0];
                    end
                    DATA: begin
                        if (bit_idx == 3'd7) begin
                            state   <= PARITY;
                            data_tx <= par_bit;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shreg   <= shreg >> 1;
                            data_tx <= shreg[1];
                        end
                    end
                    PARITY: begin
                        state   <= STOP;
                        stop2   <= 1'b0;
                        data_tx <= 1'b1;
                    end
                    STOP: begin
                        if (last_stop) begin
                            state       <= IDLE;
                            done_flag   <= 1'b1;
                            active_flag <= 1'b0;
                            data_tx     <= 1'b1;
                        end else begin
                            stop2 <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_unit.sv
// Bench for uart_tx_unit: scaled-clock instance checked by a line monitor + scoreboard,
// plus a default-clock instance timed on one 19200 frame.
module tb_uart_tx_unit;

    localparam int TB_HZ = 1000000;
`ifdef UART_TX_TWO_STOP_EN
    localparam int NSTOP = 2;
`else
    localparam int NSTOP = 1;
`endif

    typedef struct {
        logic [7:0] data;
        logic       par;
        int         div;
    } frame_t;

    logic       clk = 1'b0;
    logic       reset, send;
    logic [7:0] data_in;
    logic [1:0] parity_type, baud_rate;
    logic       data_tx, active_flag, done_flag;
    logic       d_send;
    logic [7:0] d_data;
    logic [1:0] d_ptype, d_baud;
    logic       d_tx, d_active, d_done;

    always #5 clk = ~clk;

    uart_tx_unit #(.CLK_HZ(TB_HZ)) dut (
        .clock(clk), .reset(reset), .send(send), .data_in(data_in),
        .parity_type(parity_type), .baud_rate(baud_rate),
        .data_tx(data_tx), .active_flag(active_flag), .done_flag(done_flag)
    );

    uart_tx_unit dut_def (
        .clock(clk), .reset(reset), .send(d_send), .data_in(d_data),
        .parity_type(d_ptype), .baud_rate(d_baud),
        .data_tx(d_tx), .active_flag(d_active), .done_flag(d_done)
    );

    int errors = 0;
    int checks = 0;
    int cycle = 0;
    int starts = 0;
    int dones = 0;
    int last_done_cyc = -100;
    int last_gap = 0;
    frame_t q[$];

    always @(posedge clk) cycle++;

    // 1 MHz clock: round(1e6/baud)
    function automatic int exp_div(input logic [1:0] b);
        case (b)
            2'b00:   return 417;
            2'b01:   return 208;
            2'b10:   return 104;
            default: return 52;
        endcase
    endfunction

    function automatic logic exp_par(input logic [7:0] d, input logic [1:0] p);
        int ones;
        ones = $countones(d);
        if (p == 2'b01) return (ones % 2 == 0);
        if (p == 2'b10) return (ones % 2 == 1);
        return 1'b1;
    endfunction

    function automatic logic exp_bit(input frame_t f, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return f.data[idx-1];
        if (idx == 9) return f.par;
        return 1'b1;
    endfunction

    // line monitor: pops an expected frame at each start bit, checks every cycle
    bit     in_frame = 1'b0;
    bit     post = 1'b0;
    frame_t cur;
    int     fc, total, nbad, bad_cyc;
    logic   e, bad_tx, bad_e, bad_a, bad_d;

    always @(negedge clk) begin
        if (reset) begin
            in_frame = 1'b0;
            post = 1'b0;
        end else begin
            if (post) begin
                post = 1'b0;
                checks++;
                if (done_flag !== 1'b0) begin
                    errors++;
                    $display("FAIL done_single: done_flag=%b, want 0 one cycle after pulse", done_flag);
                end
            end
            if (!in_frame && data_tx === 1'b0) begin
                starts++;
                last_gap = cycle - last_done_cyc;
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_start: line low at cycle %0d, no frame expected", cycle);
                end else begin
                    cur = q.pop_front();
                    in_frame = 1'b1;
                    total = (10 + NSTOP) * cur.div;
                    fc = 0;
                    nbad = 0;
                end
            end
            if (in_frame) begin
                if (fc < total) begin
                    e = exp_bit(cur, fc / cur.div);
                    if (data_tx !== e || active_flag !== 1'b1 || done_flag !== 1'b0) begin
                        if (nbad == 0) begin
                            bad_cyc = fc; bad_tx = data_tx; bad_e = e;
                            bad_a = active_flag; bad_d = done_flag;
                        end
                        nbad++;
                    end
                    fc++;
                end else begin
                    checks++;
                    if (nbad != 0) begin
                        errors++;
                        $display("FAIL frame_bits: data=%h first bad frame cycle %0d tx=%b want %b active=%b done=%b (%0d bad cycles)",
                                 cur.data, bad_cyc, bad_tx, bad_e, bad_a, bad_d, nbad);
                    end
                    checks++;
                    if (done_flag !== 1'b1 || active_flag !== 1'b0 || data_tx !== 1'b1) begin
                        errors++;
                        $display("FAIL done_pulse: data=%h done=%b active=%b tx=%b, want 1 0 1 at cycle %0d",
                                 cur.data, done_flag, active_flag, data_tx, total);
                    end
                    in_frame = 1'b0;
                    post = 1'b1;
                    dones++;
                    last_done_cyc = cycle;
                end
            end
        end
    end

    task automatic wait_dones(input int n, input int budget, input string name);
        int k = 0;
        while (dones < n && k < budget) begin
            @(negedge clk); #1;
            k++;
        end
        checks++;
        if (dones < n) begin
            errors++;
            $display("FAIL %s_timeout: dones=%0d, want %0d within %0d cycles", name, dones, n, budget);
        end
        @(negedge clk); #1;
    endtask

    task automatic kick(input logic [7:0] d, input logic [1:0] p, input logic [1:0] b);
        frame_t f;
        f.data = d; f.par = exp_par(d, p); f.div = exp_div(b);
        q.push_back(f);
        data_in = d; parity_type = p; baud_rate = b; send = 1'b1;
        @(negedge clk); #1;
        send = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; send = 1'b1; data_in = 8'h00; parity_type = 2'b01; baud_rate = 2'b11;
        d_send = 1'b0; d_data = 8'h00; d_ptype = 2'b00; d_baud = 2'b00;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            checks++;
            if (data_tx !== 1'b1 || active_flag !== 1'b0 || done_flag !== 1'b0) begin
                errors++;
                $display("FAIL reset_state: cycle %0d tx=%b active=%b done=%b, want 1 0 0",
                         i, data_tx, active_flag, done_flag);
            end
        end
        send = 1'b0; reset = 1'b0;
        @(negedge clk); #1;
    endtask

    task automatic test_odd_9600();
        int base = dones;
        kick(8'hAA, 2'b01, 2'b10);
        wait_dones(base + 1, 11 * 104 * 2 + 50, "odd_9600");
    endtask

    task automatic test_even_19200();
        int base = dones;
        kick(8'hAA, 2'b10, 2'b11);
        wait_dones(base + 1, 12 * 52 * 2 + 50, "even_19200");
    endtask

    task automatic test_all_rates();
        for (int b = 0; b < 4; b++) begin
            int base = dones;
            kick(8'h96 ^ 8'(b), 2'(b % 3), 2'(b));
            wait_dones(base + 1, 12 * 417 + 50, "rate");
        end
    endtask

    task automatic test_no_parity();
        int base = dones;
        kick(8'h01, 2'b00, 2'b11);
        wait_dones(base + 1, 12 * 52 + 50, "nopar_00");
        kick(8'h01, 2'b11, 2'b11);
        wait_dones(base + 2, 12 * 52 + 50, "nopar_11");
    endtask

    task automatic test_back_to_back();
        int base = dones;
        int bs = starts;
        int k = 0;
        frame_t f;
        f.data = 8'hC3; f.par = exp_par(8'hC3, 2'b01); f.div = 52;
        q.push_back(f);
        q.push_back(f);
        data_in = 8'hC3; parity_type = 2'b01; baud_rate = 2'b11; send = 1'b1;
        while (starts < bs + 2 && k < 2 * 12 * 52 + 50) begin
            @(negedge clk); #1;
            k++;
        end
        send = 1'b0;
        wait_dones(base + 2, 12 * 52 + 50, "b2b");
        checks++;
        if (last_gap !== 1) begin
            errors++;
            $display("FAIL b2b_gap: second start %0d cycles after done, want 1", last_gap);
        end
        repeat (3 * 52) @(negedge clk);
        #1;
        checks++;
        if (dones !== base + 2 || starts !== bs + 2) begin
            errors++;
            $display("FAIL b2b_count: frames=%0d starts=%0d, want 2 2", dones - base, starts - bs);
        end
    endtask

    task automatic test_reset_mid();
        int base = dones;
        kick(8'h3C, 2'b10, 2'b10);
        repeat (104 * 3 + 20) @(negedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (data_tx !== 1'b1 || active_flag !== 1'b0 || done_flag !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: tx=%b active=%b done=%b, want 1 0 0", data_tx, active_flag, done_flag);
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (dones !== base || data_tx !== 1'b1) begin
            errors++;
            $display("FAIL reset_abort: dones=%0d tx=%b, want %0d 1", dones, data_tx, base);
        end
        kick(8'h3C, 2'b10, 2'b10);
        wait_dones(base + 1, 12 * 104 + 50, "reset_fresh");
    endtask

    task automatic test_midframe_change();
        int base = dones;
        kick(8'h5A, 2'b10, 2'b11);
        repeat (3 * 52) @(negedge clk);
        #1;
        data_in = 8'hFF; baud_rate = 2'b00; parity_type = 2'b01;
        wait_dones(base + 1, 12 * 52 + 50, "midchange");
    endtask

    task automatic test_default_rate();
        int n = 0;
        logic par = 1'bx;
        d_data = 8'hAA; d_ptype = 2'b10; d_baud = 2'b11; d_send = 1'b1;
        @(negedge clk); #1;
        d_send = 1'b0; d_data = 8'h00; d_baud = 2'b00;
        while (d_active === 1'b1 && n < 40000) begin
            if (n == 9 * 2604 + 1302) par = d_tx;
            n++;
            @(negedge clk); #1;
        end
        checks++;
        if (n !== (10 + NSTOP) * 2604) begin
            errors++;
            $display("FAIL default_frame_len: active %0d cycles, want %0d", n, (10 + NSTOP) * 2604);
        end
        checks++;
        if (d_done !== 1'b1) begin
            errors++;
            $display("FAIL default_done: done=%b at frame end, want 1", d_done);
        end
        checks++;
        if (par !== 1'b0) begin
            errors++;
            $display("FAIL default_parity: parity bit=%b, want 0", par);
        end
    endtask

    initial begin
        test_reset();
        test_odd_9600();
        test_even_19200();
        test_all_rates();
        test_no_parity();
        test_back_to_back();
        test_reset_mid();
        test_midframe_change();
        test_default_rate();
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL missing_frames: %0d expected frames never started", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

endmodule
